// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - decode-side immediate request/result handshake bundle

interface imm_extend_pipe_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      ImmSrc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ImmExtended;
    logic            imm_illegal;
    logic [7:0]      illegal_count;

    modport slave (
        input  in_valid,
        input  instr,
        input  ImmSrc,
        input  out_ready,
        output in_ready,
        output out_valid,
        output ImmExtended,
        output imm_illegal,
        output illegal_count
    );

    modport master (
        output in_valid,
        output instr,
        output ImmSrc,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  ImmExtended,
        input  imm_illegal,
        input  illegal_count
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - RISC-V immediate extension with a 2-entry decoupling buffer

module imm_extend_pipe #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    imm_extend_pipe_if.slave     bus
);
    localparam logic [2:0] SRC_I     = 3'b000;
    localparam logic [2:0] SRC_S     = 3'b001;
    localparam logic [2:0] SRC_B     = 3'b010;
    localparam logic [2:0] SRC_J     = 3'b011;
    localparam logic [2:0] SRC_U     = 3'b100;
    localparam logic [2:0] SRC_SHAMT = 3'b101;
    localparam logic [2:0] SRC_ZIMM  = 3'b110;

    logic [XLEN-1:0] mem_imm [2];
    logic            mem_ill [2];
    logic [1:0]      count;
    logic            head;
    logic            tail;
    logic [7:0]      ill_cnt;

    logic            push;
    logic            pop;
    logic [XLEN-1:0] push_imm;
    logic            push_ill;

    logic signed [11:0] i_imm;
    logic signed [11:0] s_imm;
    logic signed [12:0] b_imm;
    logic signed [20:0] j_imm;
    logic signed [31:0] u_imm;

    // Opcode bits never contribute to any immediate format.
    logic unused_opcode;
    assign unused_opcode = ^bus.instr[6:0];

    assign i_imm = bus.instr[31:20];
    assign s_imm = {bus.instr[31:25], bus.instr[11:7]};
    assign b_imm = {bus.instr[31], bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
    assign j_imm = {bus.instr[31], bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};
    assign u_imm = {bus.instr[31:12], 12'b0};

    // Signed sources widen by sign extension through the size casts.
    always_comb begin
        push_imm = '0;
        push_ill = 1'b0;
        case (bus.ImmSrc)
            SRC_I:     push_imm = XLEN'(i_imm);
            SRC_S:     push_imm = XLEN'(s_imm);
            SRC_B:     push_imm = XLEN'(b_imm);
            SRC_J:     push_imm = XLEN'(j_imm);
            SRC_U:     push_imm = XLEN'(u_imm);
            SRC_SHAMT: begin
                if (XLEN == 64) begin
                    push_imm = XLEN'(bus.instr[25:20]);
                end else begin
                    push_imm = XLEN'(bus.instr[24:20]);
                end
            end
            SRC_ZIMM:  push_imm = XLEN'(bus.instr[19:15]);
            default:   push_ill = 1'b1;
        endcase
    end

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= 2'd0;
            head    <= 1'b0;
            tail    <= 1'b0;
            ill_cnt <= 8'd0;
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) begin
                tail <= ~tail;
                if (push_ill && ill_cnt != 8'hFF) begin
                    ill_cnt <= ill_cnt + 8'd1;
                end
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem_imm[tail] <= push_imm;
            mem_ill[tail] <= push_ill;
        end
    end

    assign bus.ImmExtended   = bus.out_valid ? mem_imm[head] : '0;
    assign bus.imm_illegal   = bus.out_valid ? mem_ill[head] : 1'b0;
    assign bus.illegal_count = ill_cnt;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - randomized and directed checks of imm_extend_pipe against a queue model

module tb_imm_extend_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  ImmSrc;
    logic        out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] imm64;
        logic [63:0] imm32;
        bit          ill;
    } ent_t;

    ent_t exp_q[$];
    int   exp_ill_cnt;

    imm_extend_pipe_if #(.XLEN(32)) b32 ();
    imm_extend_pipe_if #(.XLEN(64)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.instr     = instr;
    assign b32.ImmSrc    = ImmSrc;
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.instr     = instr;
    assign b64.ImmSrc    = ImmSrc;
    assign b64.out_ready = out_ready;

    imm_extend_pipe #(.XLEN(32)) u32 (.clk(clk), .reset(reset), .flush(flush), .bus(b32));
    imm_extend_pipe #(.XLEN(64)) u64 (.clk(clk), .reset(reset), .flush(flush), .bus(b64));

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_imm(logic [31:0] w, logic [2:0] src, bit x64);
        longint v;
        case (src)
            3'd0: begin v = w[31:20]; if (w[31]) v = v - 4096; end
            3'd1: begin v = {w[31:25], w[11:7]}; if (w[31]) v = v - 4096; end
            3'd2: begin v = {w[31], w[7], w[30:25], w[11:8], 1'b0}; if (w[31]) v = v - 8192; end
            3'd3: begin v = {w[31], w[19:12], w[20], w[30:21], 1'b0}; if (w[31]) v = v - (longint'(1) << 21); end
            3'd4: begin v = longint'(w[31:12]) * 4096; if (w[31]) v = v - (longint'(1) << 32); end
            3'd5: v = x64 ? longint'(w[25:20]) : longint'(w[24:20]);
            3'd6: v = w[19:15];
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit v, logic [31:0] w, logic [2:0] s);
        in_valid = v;
        instr    = w;
        ImmSrc   = s;
    endtask

    task automatic step();
        ent_t e;
        bit   was_full;
        logic [63:0] e32, e64;
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            exp_ill_cnt = 0;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            was_full = (exp_q.size() >= 2);
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && !was_full) begin
                e.imm64 = ref_imm(instr, ImmSrc, 1'b1);
                e.imm32 = {32'b0, ref_imm(instr, ImmSrc, 1'b0)[31:0]};
                e.ill   = (ImmSrc == 3'd7);
                exp_q.push_back(e);
                if (e.ill && exp_ill_cnt < 255) exp_ill_cnt++;
            end
        end
        #1;
        e32 = (exp_q.size() > 0) ? exp_q[0].imm32 : 64'd0;
        e64 = (exp_q.size() > 0) ? exp_q[0].imm64 : 64'd0;
        chk("in_ready32",  64'(b32.in_ready),      64'(exp_q.size() < 2));
        chk("in_ready64",  64'(b64.in_ready),      64'(exp_q.size() < 2));
        chk("out_valid32", 64'(b32.out_valid),     64'(exp_q.size() > 0));
        chk("out_valid64", 64'(b64.out_valid),     64'(exp_q.size() > 0));
        chk("imm32",       64'(b32.ImmExtended),   e32);
        chk("imm64",       b64.ImmExtended,        e64);
        chk("ill32",       64'(b32.imm_illegal),   64'(exp_q.size() > 0 && exp_q[0].ill));
        chk("ill64",       64'(b64.imm_illegal),   64'(exp_q.size() > 0 && exp_q[0].ill));
        chk("ill_cnt32",   64'(b32.illegal_count), 64'(exp_ill_cnt));
        chk("ill_cnt64",   64'(b64.illegal_count), 64'(exp_ill_cnt));
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 3'd0);
        exp_ill_cnt = 0;
        step();
        reset = 1'b0;
        step();
        chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
        chk("rst_out_valid", 64'(b32.out_valid), 64'd0);

        // Back-to-back formats, drained at one per cycle
        drive(1'b1, 32'hFFF00093, 3'd0); step(); chk("seq_I", 64'(b32.ImmExtended), 64'hFFFFFFFF);
        drive(1'b1, 32'hFE512E23, 3'd1); step(); chk("seq_S", 64'(b32.ImmExtended), 64'hFFFFFFFC);
        drive(1'b1, 32'hFE000EE3, 3'd2); step(); chk("seq_B", 64'(b32.ImmExtended), 64'hFFFFFFFC);
        drive(1'b1, 32'h0080006F, 3'd3); step(); chk("seq_J", 64'(b32.ImmExtended), 64'h00000008);
        drive(1'b1, 32'h123450B7, 3'd4); step(); chk("seq_U", 64'(b32.ImmExtended), 64'h12345000);
        drive(1'b1, 32'h800000B7, 3'd4); step(); chk("u64_sext", b64.ImmExtended, 64'hFFFFFFFF80000000);
        drive(1'b1, 32'h03F0D093, 3'd5); step();
        chk("shamt64", b64.ImmExtended, 64'h3F);
        chk("shamt32", 64'(b32.ImmExtended), 64'h1F);
        drive(1'b1, 32'h000F5073, 3'd6); step(); chk("zimm", 64'(b32.ImmExtended), 64'h1E);
        drive(1'b0, 32'h0, 3'd0); step();

        // Backpressure: third push refused until a pop frees a slot
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 3'd0); step();
        drive(1'b1, 32'h00200093, 3'd0); step(); chk("full_ready", 64'(b32.in_ready), 64'd0);
        drive(1'b1, 32'h00300093, 3'd0); step(); chk("full_hold", 64'(b32.ImmExtended), 64'd1);
        drive(1'b0, 32'h0, 3'd0);
        out_ready = 1'b1;
        step(); chk("pop_ready", 64'(b32.in_ready), 64'd1); chk("pop_order", 64'(b32.ImmExtended), 64'd2);
        step(); chk("drained", 64'(b32.out_valid), 64'd0);

        // Interleaved pushes and stalls to walk the pointers around
        for (int i = 0; i < 12; i++) begin
            out_ready = (i % 3) == 2;
            drive(1'b1, {12'(i + 16), 20'h00093}, 3'd0);
            step();
        end
        drive(1'b0, 32'h0, 3'd0); out_ready = 1'b1; step(); step();

        // Flush with two buffered and a discarded illegal push
        out_ready = 1'b0;
        drive(1'b1, 32'h00500093, 3'd0); step();
        drive(1'b1, 32'h00600093, 3'd0); step();
        flush = 1'b1; drive(1'b1, 32'h0, 3'd7); step();
        flush = 1'b0;
        chk("flush_valid", 64'(b32.out_valid), 64'd0);
        chk("flush_ready", 64'(b32.in_ready), 64'd1);
        chk("flush_cnt", 64'(b32.illegal_count), 64'd0);
        drive(1'b0, 32'h0, 3'd0); out_ready = 1'b1; step();
        chk("flush_gone", 64'(b32.out_valid), 64'd0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 31) == 0;
            instr     = $urandom;
            ImmSrc    = 3'($urandom_range(0, 7));
            step();
        end
        flush = 1'b0;

        // Illegal flood to saturation
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, $urandom, 3'd7);
            step();
        end
        chk("sat_cnt", 64'(b32.illegal_count), 64'd255);
        drive(1'b1, 32'h000F5073, 3'd6); step(); chk("zimm2", 64'(b32.ImmExtended), 64'h1E);
        drive(1'b0, 32'h0, 3'd0); step();

        // Reset with one entry buffered
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 3'd0); step();
        drive(1'b0, 32'h0, 3'd0);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mrst_valid", 64'(b32.out_valid), 64'd0);
        chk("mrst_ready", 64'(b32.in_ready), 64'd1);
        chk("mrst_cnt", 64'(b32.illegal_count), 64'd0);
        chk("mrst_imm", b64.ImmExtended, 64'd0);
        out_ready = 1'b1; step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
